interrupt_context_unit: RTL and testbench

CPU-side responder for the interrupt controller's request/finish handshake. It detects a new request on `s_interruption`, saves the interrupted PC and ALU flags on a small hardware return stack, and redirects the fetch unit to the vector on `dir_in`. On a decoded return-from-interrupt instruction it restores PC and flags and pulses `s_finished` back to the controller. It sits between the interrupt controller and the PC/flag registers of the processor datapath.

---
 rtl/interrupt_context_unit.sv | 122 ++++++++++++
 tb/tb_interrupt_context_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_context_unit.sv
// interrupt_context_unit
// CPU-side responder for the interrupt controller's request/finish handshake.
// A rising edge on s_interruption latches the vector and marks a request pending.
// When the request is serviced, the return PC and the ALU flags are pushed onto a small
// hardware stack and the fetch unit is redirected to the vector. A reti pops the stack,
// restores PC and flags, and pulses s_finished back to the controller.
//
// Handshake: s_interruption is a level. Only its 0->1 edge raises a request, and dir_in is
// valid in that cycle. s_finished is a one-cycle pulse, issued for every successful return.
// pc_load and flags_restore are one-cycle strobes. pc_target and flags_out are meaningful
// while their strobes are high, and they hold their last value otherwise.
module interrupt_context_unit #(
   parameter int PC_W   = 10,
   parameter int FLAG_W = 2,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     s_interruption,
   input  logic [PC_W-1:0]          dir_in,
   input  logic                     int_enable,
   input  logic [PC_W-1:0]          pc_next,
   input  logic [FLAG_W-1:0]        flags_in,
   input  logic                     reti,
   output logic                     pc_load,
   output logic [PC_W-1:0]          pc_target,
   output logic                     flags_restore,
   output logic [FLAG_W-1:0]        flags_out,
   output logic                     s_finished,
   output logic                     in_isr,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     err_reti
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;
   localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
   localparam logic [DW-1:0] ONE       = DW'(1);
   localparam logic [AW-1:0] IDX_ONE   = AW'(1);

   logic              req_q;
   logic              pending;
   logic [PC_W-1:0]   vec_q;
   logic [PC_W-1:0]   stack_pc    [DEPTH];
   logic [FLAG_W-1:0] stack_flags [DEPTH];

   logic              rise;
   logic              do_ret;
   logic              do_err;
   logic              do_enter;
   logic [AW-1:0]     push_idx;
   logic [AW-1:0]     pop_idx;

   // Decide this cycle's action. A return beats entry, and entry needs a free slot.
   always_comb begin
      rise     = 1'b0;
      do_ret   = 1'b0;
      do_err   = 1'b0;
      do_enter = 1'b0;
      push_idx = depth[AW-1:0];
      pop_idx  = depth[AW-1:0] - IDX_ONE;
      rise     = s_interruption & ~req_q;
      do_ret   = reti & (depth != '0);
      do_err   = reti & (depth == '0);
      do_enter = pending & int_enable & (depth < DEPTH_MAX) & ~reti;
   end

   // Request capture, depth tracking and the registered strobes and redirect values.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_q         <= 1'b0;
         pending       <= 1'b0;
         vec_q         <= '0;
         depth         <= '0;
         in_isr        <= 1'b0;
         pc_load       <= 1'b0;
         pc_target     <= '0;
         flags_restore <= 1'b0;
         flags_out     <= '0;
         s_finished    <= 1'b0;
         err_reti      <= 1'b0;
      end else begin
         req_q <= s_interruption;
         // A new edge always wins over servicing, so a request that arrives in the
         // same cycle as an entry is kept for later.
         if (rise) begin
            pending <= 1'b1;
            vec_q   <= dir_in;
         end else if (do_enter) begin
            pending <= 1'b0;
         end
         pc_load       <= do_enter | do_ret;
         flags_restore <= do_ret;
         s_finished    <= do_ret;
         err_reti      <= do_err;
         if (do_ret) begin
            pc_target <= stack_pc[pop_idx];
            flags_out <= stack_flags[pop_idx];
            depth     <= depth - ONE;
            in_isr    <= (depth != ONE);
         end else if (do_enter) begin
            pc_target <= vec_q;
            depth     <= depth + ONE;
            in_isr    <= 1'b1;
         end
      end
   end

   // Return stack storage: write the interrupted context at the current depth on entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stack_pc[i]    <= '0;
            stack_flags[i] <= '0;
         end
      end else if (do_enter) begin
         stack_pc[push_idx]    <= pc_next;
         stack_flags[push_idx] <= flags_in;
      end
   end

endmodule

// File: tb/tb_interrupt_context_unit.sv
// tb_interrupt_context_unit
// Directed scenarios followed by random traffic. All of it is compared against a
// queue-based reference model of the return stack.
module tb_interrupt_context_unit;

   localparam int PC_W   = 10;
   localparam int FLAG_W = 2;
   localparam int DEPTH  = 4;
   localparam int DW     = $clog2(DEPTH) + 1;

   logic              clk;
   logic              reset;
   logic              s_interruption;
   logic [PC_W-1:0]   dir_in;
   logic              int_enable;
   logic [PC_W-1:0]   pc_next;
   logic [FLAG_W-1:0] flags_in;
   logic              reti;
   logic              pc_load;
   logic [PC_W-1:0]   pc_target;
   logic              flags_restore;
   logic [FLAG_W-1:0] flags_out;
   logic              s_finished;
   logic              in_isr;
   logic [DW-1:0]     depth;
   logic              err_reti;

   interrupt_context_unit #(.PC_W(PC_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .s_interruption(s_interruption), .dir_in(dir_in),
      .int_enable(int_enable), .pc_next(pc_next), .flags_in(flags_in), .reti(reti),
      .pc_load(pc_load), .pc_target(pc_target), .flags_restore(flags_restore),
      .flags_out(flags_out), .s_finished(s_finished), .in_isr(in_isr), .depth(depth),
      .err_reti(err_reti)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [PC_W-1:0] exp_q[$];

   // reference model: the stack is a queue of {flags, pc}
   logic [FLAG_W+PC_W-1:0] m_stack[$];
   logic              m_req, m_pending;
   logic [PC_W-1:0]   m_vec;
   logic              e_pc_load, e_flags_restore, e_s_finished, e_err;
   logic [PC_W-1:0]   e_pc_target;
   logic [FLAG_W-1:0] e_flags_out;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one rising edge, using the inputs the DUT is sampling.
   task automatic model_step();
      logic rise, ret, err, enter;
      logic [FLAG_W+PC_W-1:0] ent;
      if (reset) begin
         m_stack.delete();
         m_req = 0; m_pending = 0; m_vec = '0;
         e_pc_load = 0; e_flags_restore = 0; e_s_finished = 0; e_err = 0;
         e_pc_target = '0; e_flags_out = '0;
         return;
      end
      rise  = s_interruption && !m_req;
      ret   = reti && (m_stack.size() > 0);
      err   = reti && (m_stack.size() == 0);
      enter = m_pending && int_enable && (m_stack.size() < DEPTH) && !reti;
      e_pc_load       = ret || enter;
      e_flags_restore = ret;
      e_s_finished    = ret;
      e_err           = err;
      if (ret) begin
         ent = m_stack.pop_back();
         e_pc_target = ent[PC_W-1:0];
         e_flags_out = ent[FLAG_W+PC_W-1:PC_W];
      end else if (enter) begin
         m_stack.push_back({flags_in, pc_next});
         e_pc_target = m_vec;
      end
      if (e_pc_load) exp_q.push_back(e_pc_target);
      if (rise) begin
         m_pending = 1;
         m_vec = dir_in;
      end else if (enter) begin
         m_pending = 0;
      end
      m_req = s_interruption;
   endtask

   task automatic compare_all();
      check("pc_load", pc_load, e_pc_load);
      check("pc_target", pc_target, e_pc_target);
      check("flags_restore", flags_restore, e_flags_restore);
      check("flags_out", flags_out, e_flags_out);
      check("s_finished", s_finished, e_s_finished);
      check("err_reti", err_reti, e_err);
      check("depth", depth, m_stack.size());
      check("in_isr", in_isr, m_stack.size() != 0);
      if (pc_load) begin
         if (exp_q.size() > 0) check("sb_target", pc_target, exp_q.pop_front());
         else check("sb_load_without_expect", exp_q.size(), 1);
      end
   endtask

   // ---------------- driver ----------------
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_reti();
      reti = 1;
      cycle();
      reti = 0;
   endtask

   task automatic enter_one(input logic [PC_W-1:0] vec, input logic [PC_W-1:0] ret_pc);
      s_interruption = 1; dir_in = vec; pc_next = ret_pc;
      cycle();
      s_interruption = 0;
      cycle();
   endtask

   logic [PC_W-1:0] vecs [4];
   int loads;

   initial begin
      vecs[0] = 10'h3FB; vecs[1] = 10'h3FC; vecs[2] = 10'h3FD; vecs[3] = 10'h013;
      reset = 1; s_interruption = 0; dir_in = '0; int_enable = 1;
      pc_next = '0; flags_in = '0; reti = 0;
      cycle(); cycle();
      check("rst_depth", depth, 0);
      check("rst_pc_load", pc_load, 0);
      check("rst_pc_target", pc_target, 0);
      reset = 0;
      cycle();

      // basic entry and return
      s_interruption = 1; dir_in = 10'h013; pc_next = 10'h045; flags_in = 2'b01;
      cycle();
      check("basic_no_load_yet", pc_load, 0);
      cycle();
      check("basic_enter_load", pc_load, 1);
      check("basic_enter_target", pc_target, 10'h013);
      check("basic_enter_depth", depth, 1);
      s_interruption = 0;
      cycle();
      do_reti();
      check("basic_ret_target", pc_target, 10'h045);
      check("basic_ret_flags", flags_out, 2'b01);
      check("basic_ret_finished", s_finished, 1);
      check("basic_ret_depth", depth, 0);
      cycle();
      check("basic_finished_one_cycle", s_finished, 0);

      // level held high counts once
      s_interruption = 1; dir_in = 10'h155; loads = 0;
      repeat (10) begin cycle(); if (pc_load) loads++; end
      s_interruption = 0;
      cycle(); if (pc_load) loads++;
      check("level_loads", loads, 1);
      check("level_depth", depth, 1);
      do_reti();
      cycle();

      // nesting to full, fifth request held until a slot frees
      for (int i = 0; i < 4; i++) enter_one(vecs[i], PC_W'(10'h100 + i));
      check("nest_depth_full", depth, 4);
      s_interruption = 1; dir_in = 10'h2AA;
      cycle();
      s_interruption = 0; loads = 0;
      repeat (4) begin cycle(); if (pc_load) loads++; end
      check("nest_blocked_loads", loads, 0);
      check("nest_blocked_depth", depth, 4);
      do_reti();
      check("nest_pop_target", pc_target, 10'h103);
      check("nest_pop_depth", depth, 3);
      cycle();
      check("nest_reenter_load", pc_load, 1);
      check("nest_reenter_target", pc_target, 10'h2AA);
      check("nest_reenter_depth", depth, 4);
      reset = 1; cycle(); reset = 0;

      // return and a new edge in the same cycle
      enter_one(10'h0AA, 10'h077);
      check("simul_start_depth", depth, 1);
      reti = 1; s_interruption = 1; dir_in = 10'h3FC;
      cycle();
      reti = 0;
      check("simul_finished", s_finished, 1);
      check("simul_ret_target", pc_target, 10'h077);
      check("simul_mid_depth", depth, 0);
      cycle();
      check("simul_enter_load", pc_load, 1);
      check("simul_enter_target", pc_target, 10'h3FC);
      check("simul_end_depth", depth, 1);
      s_interruption = 0;
      reset = 1; cycle(); reset = 0;

      // disabled request waits for enable
      int_enable = 0; s_interruption = 1; dir_in = 10'h3FB;
      cycle();
      s_interruption = 0; loads = 0;
      repeat (5) begin cycle(); if (pc_load) loads++; end
      check("disabled_loads", loads, 0);
      int_enable = 1;
      cycle();
      check("enable_load", pc_load, 1);
      check("enable_target", pc_target, 10'h3FB);
      do_reti();
      cycle();

      // stray return
      do_reti();
      check("stray_err", err_reti, 1);
      check("stray_no_load", pc_load, 0);
      check("stray_no_finish", s_finished, 0);
      cycle();
      check("stray_err_one_cycle", err_reti, 0);

      // reset in the middle of a nested ISR
      enter_one(10'h111, 10'h222);
      enter_one(10'h333, 10'h044);
      check("midrst_depth_before", depth, 2);
      reset = 1; cycle(); reset = 0;
      check("midrst_depth", depth, 0);
      check("midrst_in_isr", in_isr, 0);
      check("midrst_pc_target", pc_target, 0);
      check("midrst_pc_load", pc_load, 0);
      do_reti();
      check("midrst_reti_err", err_reti, 1);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         reset          = ($urandom_range(0, 299) == 0);
         s_interruption = ($urandom_range(0, 2) == 0);
         dir_in         = PC_W'($urandom_range(0, 1023));
         pc_next        = PC_W'($urandom_range(0, 1023));
         flags_in       = FLAG_W'($urandom_range(0, 3));
         int_enable     = ($urandom_range(0, 4) != 0);
         reti           = ($urandom_range(0, 6) == 0);
         cycle();
      end
      reset = 0; reti = 0; s_interruption = 0;
      cycle();
      check("sb_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
